cache_counter_reader: RTL and testbench



---
 rtl/cache_counter_reader.sv | 131 +++++++++++++
 tb/tb_cache_counter_reader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_counter_reader.sv
// Snapshot reader for the cache profiler counters. One request captures every
// counter in a single cycle and streams them out as header, data and checksum words.
module cache_counter_reader #(
   parameter int NUM_COUNTERS = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        snap_req,
   input  logic [32*NUM_COUNTERS-1:0]  counters_in,
   output logic                        busy,
   output logic                        m_valid,
   output logic [31:0]                 m_data,
   output logic                        m_last,
   input  logic                        m_ready,
   output logic                        snap_done,
   output logic [15:0]                 seq_id,
   output logic [7:0]                  drop_count
);

   localparam int unsigned NC = NUM_COUNTERS;
   localparam int unsigned IW = (NC > 1) ? $clog2(NC) : 1;
   localparam logic [7:0]    NC8      = 8'(NC);
   localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEADER,
      ST_DATA,
      ST_CHECK
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     snap_q [NC];
   logic [31:0]     snap_d [NC];
   logic [IW-1:0]   idx_q, idx_d;
   logic [31:0]     csum_q, csum_d;
   logic [15:0]     seq_id_q, seq_id_d;
   logic [7:0]      drop_q, drop_d;
   logic            done_q, done_d;
   logic [31:0]     header_w;

   assign header_w = {8'hA5, NC8, seq_id_q};

   // All stream outputs derive from registered state only, so they stay
   // stable for as long as the consumer stalls.
   always_comb begin
      state_d  = state_q;
      snap_d   = snap_q;
      idx_d    = idx_q;
      csum_d   = csum_q;
      seq_id_d = seq_id_q;
      drop_d   = drop_q;
      done_d   = 1'b0;
      m_valid  = (state_q != ST_IDLE);
      m_last   = 1'b0;
      m_data   = '0;

      if (snap_req && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (snap_req) begin
               for (int unsigned k = 0; k < NC; k++) begin
                  snap_d[k] = counters_in[32*k +: 32];
               end
               csum_d  = header_w;
               state_d = ST_HEADER;
            end
         end
         ST_HEADER: begin
            m_data = header_w;
            if (m_ready) begin
               idx_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            m_data = snap_q[idx_q];
            if (m_ready) begin
               csum_d = csum_q ^ snap_q[idx_q];
               if (idx_q == LAST_IDX) begin
                  state_d = ST_CHECK;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_CHECK: begin
            m_data = csum_q;
            m_last = 1'b1;
            if (m_ready) begin
               done_d   = 1'b1;
               seq_id_d = seq_id_q + 16'd1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         csum_q   <= '0;
         seq_id_q <= '0;
         drop_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         csum_q   <= csum_d;
         seq_id_q <= seq_id_d;
         drop_q   <= drop_d;
         done_q   <= done_d;
      end
   end

   // Snapshot contents are only meaningful once a packet starts, so no reset.
   always_ff @(posedge clk) begin
      snap_q <= snap_d;
   end

   assign busy       = (state_q != ST_IDLE);
   assign snap_done  = done_q;
   assign seq_id     = seq_id_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_cache_counter_reader.sv
// Randomised bench for cache_counter_reader: each expected packet is built from the
// counter values presented at request time, a sequence number and an XOR reduction.
module tb_cache_counter_reader;

   localparam int NC = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              snap_req;
   logic [32*NC-1:0]  counters_in;
   logic              busy;
   logic              m_valid;
   logic [31:0]       m_data;
   logic              m_last;
   logic              m_ready;
   logic              snap_done;
   logic [15:0]       seq_id;
   logic [7:0]        drop_count;

   always #5 clk = ~clk;

   cache_counter_reader #(.NUM_COUNTERS(NC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .snap_req   (snap_req),
      .counters_in(counters_in),
      .busy       (busy),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_last     (m_last),
      .m_ready    (m_ready),
      .snap_done  (snap_done),
      .seq_id     (seq_id),
      .drop_count (drop_count)
   );

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          n_done;
   logic [31:0] got_q[$];
   logic        last_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] cap [NC];
   logic [15:0] m_seq;
   int          m_drop;
   logic        obs_valid, obs_last, obs_done, obs_busy;
   logic [31:0] obs_data;
   logic [31:0] diff_got, diff_exp;

   task automatic load_counters(input bit rnd);
      for (int k = 0; k < NC; k++) begin
         cap[k] = rnd ? $urandom : 32'(k + 1);
         counters_in[32*k +: 32] = cap[k];
      end
   endtask

   task automatic build_expected();
      logic [31:0] w;
      exp_q.delete();
      w = {8'hA5, 8'(NC), m_seq};
      exp_q.push_back(w);
      for (int k = 0; k < NC; k++) exp_q.push_back(cap[k]);
      exp_q.push_back(exp_q.xor());
   endtask

   // One clock: drive inputs at the falling edge, record what the next rising edge sees.
   task automatic drive_cycle(input logic req, input logic rdy);
      snap_req  = req;
      m_ready   = rdy;
      obs_valid = m_valid;
      obs_data  = m_data;
      obs_last  = m_last;
      obs_done  = snap_done;
      obs_busy  = busy;
      if (m_valid && rdy) begin
         got_q.push_back(m_data);
         last_q.push_back(m_last);
      end
      if (snap_done) n_done++;
      @(negedge clk);
   endtask

   task automatic start_capture();
      got_q.delete();
      last_q.delete();
      n_done = 0;
      build_expected();
      drive_cycle(1'b1, 1'b0);
   endtask

   task automatic drain(input int budget);
      for (int c = 0; c < budget && n_done == 0; c++) drive_cycle(1'b0, 1'b1);
   endtask

   function automatic int pkt_diff();
      int n;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         if (got_q[i] !== exp_q[i]) begin
            diff_got = got_q[i];
            diff_exp = exp_q[i];
            return i;
         end
      end
      diff_got = 'x;
      diff_exp = 'x;
      return (got_q.size() == exp_q.size()) ? -1 : n;
   endfunction

   function automatic int last_pos();
      int p = -1;
      for (int i = 0; i < last_q.size(); i++) if (last_q[i]) p = (p == -1) ? i : -2;
      return p;
   endfunction

   function automatic int sat_add(input int a, input int b);
      return (a + b > 255) ? 255 : a + b;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      drive_cycle(1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0);
      m_seq  = 16'h0;
      m_drop = 0;
      n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b need 0", m_valid); end
      n_cmp++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b need 0", m_last); end
      n_cmp++; if (snap_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b need 0", snap_done); end
      n_cmp++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h need 0", m_data); end
      n_cmp++; if (seq_id !== m_seq) begin n_fail++; $display("FAIL reset_seq: got %h need %h", seq_id, m_seq); end
      n_cmp++; if (drop_count !== 8'(m_drop)) begin n_fail++; $display("FAIL reset_drop: got %h need 0", drop_count); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
      rst_n = 1'b1;
      drive_cycle(1'b0, 1'b0);
   endtask

   task automatic test_basic();
      int d;
      load_counters(1'b0);
      start_capture();
      drive_cycle(1'b0, 1'b1);
      n_cmp++; if (obs_valid !== 1'b1 || obs_data !== exp_q[0]) begin
         n_fail++; $display("FAIL basic_latency: got valid %b data %h need 1 %h", obs_valid, obs_data, exp_q[0]);
      end
      drain(30);
      repeat (3) drive_cycle(1'b0, 1'b0);
      d = pkt_diff();
      n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL basic_pkt: word %0d got %h need %h (%0d words, need %0d)", d, diff_got, diff_exp, got_q.size(), exp_q.size()); end
      n_cmp++; if (exp_q[0] !== 32'hA508_0000 || exp_q[NC+1] !== 32'hA508_0008) begin
         n_fail++; $display("FAIL basic_model: header %h checksum %h need A5080000 A5080008", exp_q[0], exp_q[NC+1]);
      end
      n_cmp++; if (last_pos() !== NC + 1) begin n_fail++; $display("FAIL basic_last: last at %0d need %0d", last_pos(), NC + 1); end
      n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL basic_done: %0d pulses need 1", n_done); end
      m_seq++;
      n_cmp++; if (seq_id !== m_seq) begin n_fail++; $display("FAIL basic_seq: got %h need %h", seq_id, m_seq); end
   endtask

   task automatic test_stall();
      int d, stall_left, bad;
      logic rdy, prev_stall, prev_last;
      logic [31:0] prev_data;
      stall_left = 0; bad = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
      load_counters(1'b1);
      start_capture();
      for (int c = 0; c < 300 && got_q.size() < NC + 2; c++) begin
         if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
         else if ($urandom_range(5) == 0) begin rdy = 1'b0; stall_left = 4; end
         else rdy = 1'($urandom_range(1));
         drive_cycle(1'b0, rdy);
         if (prev_stall && (obs_valid !== 1'b1 || obs_data !== prev_data || obs_last !== prev_last)) bad++;
         prev_stall = obs_valid && !rdy;
         prev_data  = obs_data;
         prev_last  = obs_last;
      end
      repeat (2) drive_cycle(1'b0, 1'b0);
      d = pkt_diff();
      n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL stall_pkt: word %0d got %h need %h (%0d words)", d, diff_got, diff_exp, got_q.size()); end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL stall_hold: %0d unstable stalled cycles need 0", bad); end
      n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL stall_done: %0d pulses need 1", n_done); end
      m_seq++;
      n_cmp++; if (seq_id !== m_seq) begin n_fail++; $display("FAIL stall_seq: got %h need %h", seq_id, m_seq); end
   endtask

   task automatic test_no_tear();
      int d;
      load_counters(1'b1);
      start_capture();
      counters_in = '1;
      drain(30);
      d = pkt_diff();
      n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL notear_pkt: word %0d got %h need %h", d, diff_got, diff_exp); end
      m_seq++;
      drive_cycle(1'b0, 1'b0);
   endtask

   task automatic test_drops();
      int d;
      load_counters(1'b1);
      start_capture();
      for (int i = 1; i <= 12; i++) drive_cycle(i == 2 || i == 4 || i == 6, 1'b1);
      repeat (4) drive_cycle(1'b0, 1'b1);
      m_drop = sat_add(m_drop, 3);
      m_seq++;
      d = pkt_diff();
      n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL drop_pkt: word %0d got %h need %h (%0d words)", d, diff_got, diff_exp, got_q.size()); end
      n_cmp++; if (drop_count !== 8'(m_drop)) begin n_fail++; $display("FAIL drop_three: got %h need %h", drop_count, 8'(m_drop)); end
      n_cmp++; if (n_done !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_one_pkt: pulses %0d busy %b need 1 0", n_done, busy); end
      load_counters(1'b1);
      start_capture();
      counters_in = '0;
      repeat (300) drive_cycle(1'b1, 1'b0);
      m_drop = sat_add(m_drop, 300);
      n_cmp++; if (drop_count !== 8'(m_drop)) begin n_fail++; $display("FAIL drop_sat: got %h need %h", drop_count, 8'(m_drop)); end
      drain(30);
      m_seq++;
      d = pkt_diff();
      n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL drop_sat_pkt: word %0d got %h need %h", d, diff_got, diff_exp); end
   endtask

   task automatic test_back_to_back();
      int d;
      load_counters(1'b1);
      start_capture();
      repeat (NC + 2) drive_cycle(1'b0, 1'b1);
      d = pkt_diff();
      n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL b2b_first: word %0d got %h need %h", d, diff_got, diff_exp); end
      m_seq++;
      load_counters(1'b1);
      start_capture();
      n_cmp++; if (obs_done !== 1'b1 || obs_busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b_slot: done %b busy %b need 1 0", obs_done, obs_busy);
      end
      n_done = 0;
      drain(30);
      m_seq++;
      d = pkt_diff();
      n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL b2b_second: word %0d got %h need %h (%0d words)", d, diff_got, diff_exp, got_q.size()); end
      n_cmp++; if (drop_count !== 8'(m_drop)) begin n_fail++; $display("FAIL b2b_drop: got %h need %h", drop_count, 8'(m_drop)); end
   endtask

   task automatic test_reset_abort();
      int d, n_words;
      load_counters(1'b1);
      start_capture();
      repeat (5) drive_cycle(1'b0, 1'b1);
      rst_n = 1'b0;
      drive_cycle(1'b0, 1'b1);
      rst_n  = 1'b1;
      m_seq  = 16'h0;
      m_drop = 0;
      n_cmp++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin n_fail++; $display("FAIL abort_valid: valid %b last %b need 0 0", m_valid, m_last); end
      n_cmp++; if (seq_id !== m_seq) begin n_fail++; $display("FAIL abort_seq: got %h need %h", seq_id, m_seq); end
      n_words = got_q.size();
      repeat (3) drive_cycle(1'b0, 1'b1);
      n_cmp++; if (got_q.size() !== n_words) begin n_fail++; $display("FAIL abort_tail: %0d stray words need 0", got_q.size() - n_words); end
      load_counters(1'b0);
      start_capture();
      drain(30);
      m_seq++;
      d = pkt_diff();
      n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL abort_new_pkt: word %0d got %h need %h (%0d words)", d, diff_got, diff_exp, got_q.size()); end
   endtask

   task automatic test_seq_wrap();
      int d;
      force dut.seq_id_q = 16'hFFFF;
      @(posedge clk);
      #1 release dut.seq_id_q;
      @(negedge clk);
      m_seq = 16'hFFFF;
      n_cmp++; if (seq_id !== m_seq) begin n_fail++; $display("FAIL wrap_preset: got %h need %h", seq_id, m_seq); end
      load_counters(1'b1);
      start_capture();
      drain(30);
      m_seq++;
      d = pkt_diff();
      n_cmp++; if (d !== -1) begin n_fail++; $display("FAIL wrap_pkt: word %0d got %h need %h", d, diff_got, diff_exp); end
      n_cmp++; if (seq_id !== m_seq) begin n_fail++; $display("FAIL wrap_seq: got %h need %h", seq_id, m_seq); end
   endtask

   initial begin
      rst_n       = 1'b0;
      snap_req    = 1'b0;
      m_ready     = 1'b0;
      counters_in = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      repeat (3) test_stall();
      test_no_tear();
      test_drops();
      test_back_to_back();
      test_reset_abort();
      test_seq_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
